cost_table: RTL

COST_TABLE -- requirements
Module: cost_table

---
 rtl/jam_pkg.sv | 11 +
 rtl/cost_ram.sv | 45 ++++
 rtl/cost_table.sv | 107 ++++++++++
 3 files changed

// File: rtl/jam_pkg.sv
// Shared sizing and FSM state encoding for the assignment-search cost table.
// Row-major addressing assumes N = 8 so that {W,J} is a 6-bit entry index.
package jam_pkg;
    localparam int N      = 8;
    localparam int COST_W = 7;
    localparam int ADDR_W = 6;

    typedef logic [0:0] state_t;
    localparam state_t LOAD  = 1'b0;
    localparam state_t SERVE = 1'b1;
endpackage

// File: rtl/cost_ram.sv
// N*N cost storage: one write port, one registered read port (zero when re is low).
// Latency 1 cycle read; no backpressure, write-first forwarding on address collision.
// Storage is not reset; only the read register is.
module cost_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Forward a same-cycle write so the final load entry is visible on the first SERVE read.
    always_comb begin
        rdata_d = '0;
        if (re) begin
            rdata_d = (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/cost_table.sv
// Loads an N*N cost matrix row-major, then serves registered lookups of (W,J).
// Latency: Cost 1 cycle after W/J; LdReady high only while loading, Clear restarts the load.
// COST_CHECKSUM_EN enables the LoadSum accumulator; otherwise LoadSum is tied to 0.
module cost_table #(
    parameter int N      = jam_pkg::N,
    parameter int COST_W = jam_pkg::COST_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              Clear,
    input  logic              LdValid,
    input  logic [COST_W-1:0] LdData,
    output logic              LdReady,
    output logic              TableValid,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    output logic [15:0]       LoadSum
);
    import jam_pkg::state_t;
    import jam_pkg::LOAD;
    import jam_pkg::SERVE;
    import jam_pkg::ADDR_W;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N * N - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              tv_q, tv_d;
    logic              accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tv_d    = tv_q;
        accept  = LdValid && (state_q == LOAD) && !Clear;
        if (Clear) begin
            state_d = LOAD;
            cnt_d   = '0;
            tv_d    = 1'b0;
        end else if (accept) begin
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                state_d = SERVE;
                tv_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            tv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tv_q    <= tv_d;
        end
    end

    assign LdReady    = (state_q == LOAD);
    assign TableValid = tv_q;

    // Read enable follows the next state so Cost is zero for every cycle spent in LOAD.
    cost_ram #(
        .DEPTH (N * N),
        .AW    (ADDR_W),
        .DW    (COST_W)
    ) u_cost_ram (
        .clk   (CLK),
        .rst_n (RST_N),
        .we    (accept),
        .waddr (cnt_q),
        .wdata (LdData),
        .re    (state_d == SERVE),
        .raddr ({W, J}),
        .rdata (Cost)
    );

`ifdef COST_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (Clear) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + 16'(LdData);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign LoadSum = sum_q;
`else
    assign LoadSum = 16'd0;
`endif
endmodule
